f2r_rom_streamer: RTL and testbench

- Producer side of the ROM-to-F2R stream. When F2R_Block raises its ROM enable, this block fetches a configured run of signed elements from a synchronous-read block RAM and presents them as data/valid.
- It signals read-done after the last element.
- It sits between the weight/feature BRAM and the F2R_Block ROM port, one instance per F2R_Block.

---
 rtl/f2r_rom_streamer.sv | 160 ++++++++++++++++
 tb/tb_f2r_rom_streamer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/f2r_rom_streamer.sv
// ROM-to-F2R stream producer: fetches a configured run of signed elements from a BRAM and streams them out.
// Optional F2R_ROM_STREAMER_CHECKSUM_EN adds o_checksum, the wrapping sum of elements emitted in the current run.
module f2r_rom_streamer #(
  parameter int DATA_SIZE    = 8,
  parameter int ADDR_WIDTH   = 12,
  parameter int LEN_WIDTH    = 16,
  parameter int READ_LATENCY = 1,
  parameter int SKID_DEPTH   = READ_LATENCY + 1
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_set_param,
  input  logic [ADDR_WIDTH-1:0]        i_base_addr,
  input  logic [LEN_WIDTH-1:0]         i_length,
  input  logic                         i_en_rom,
  output logic signed [DATA_SIZE-1:0]  o_rom_to_f2r_data,
  output logic                         o_rom_to_f2r_valid,
  output logic                         o_rom_read_done,
  output logic                         o_bram_en,
  output logic [ADDR_WIDTH-1:0]        o_bram_addr,
  input  logic signed [DATA_SIZE-1:0]  i_bram_rdata,
  output logic                         o_busy
`ifdef F2R_ROM_STREAMER_CHECKSUM_EN
  ,
  output logic [15:0]                  o_checksum
`endif
);

  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam int OW = $clog2(SKID_DEPTH + READ_LATENCY + 2) + 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t                       state_q, state_d;
  logic [ADDR_WIDTH-1:0]        base_q;
  logic [LEN_WIDTH-1:0]         len_q, issued_q, issued_d, emitted_q, emitted_d;
  logic [READ_LATENCY:0]        pipe_q;
  logic signed [DATA_SIZE-1:0]  buf_q [SKID_DEPTH];
  logic [PW-1:0]                rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]                count_q, count_d;
  logic signed [DATA_SIZE-1:0]  data_q;
  logic                         valid_q, done_q, bram_en_q, busy_q;
  logic [ADDR_WIDTH-1:0]        bram_addr_q;

  logic                         active, set_ok, arriving, buf_empty;
  logic                         pop, pop_buf, push, issue, start;
  logic signed [DATA_SIZE-1:0]  head;
  logic [OW-1:0]                inflight, occ_after;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    active    = (state_q == STREAM) || (state_q == DRAIN);
    set_ok    = i_set_param && ((state_q == IDLE) || (state_q == DONE));
    arriving  = pipe_q[READ_LATENCY];
    buf_empty = (count_q == '0);
    // Arriving data bypasses the buffer when it is empty, so the first element
    // reaches the output register on the cycle it returns from the BRAM.
    pop       = active && i_en_rom && (!buf_empty || arriving);
    pop_buf   = pop && !buf_empty;
    push      = arriving && !(pop && buf_empty);
    head      = buf_empty ? i_bram_rdata : buf_q[rd_ptr_q];
    inflight  = OW'($countones(pipe_q[READ_LATENCY-1:0]));
    occ_after = OW'(count_q) + OW'(arriving) - OW'(pop);
    issue     = (state_q == STREAM) && i_en_rom && (issued_q < len_q) &&
                ((occ_after + inflight) < OW'(SKID_DEPTH));
    issued_d  = issued_q + LEN_WIDTH'(issue);
    emitted_d = emitted_q + LEN_WIDTH'(pop);
    count_d   = count_q + CW'(push) - CW'(pop_buf);
    start     = 1'b0;
    state_d   = state_q;
    case (state_q)
      IDLE: begin
        if (!set_ok && i_en_rom) begin
          if (len_q != '0) begin
            state_d = STREAM;
            start   = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      STREAM: if (issued_d == len_q) state_d = DRAIN;
      DRAIN:  if (emitted_d == len_q) state_d = DONE;
      DONE:   if (set_ok || !i_en_rom) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      emitted_q   <= '0;
      pipe_q      <= '0;
      buf_q       <= '{default: '0};
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      bram_en_q   <= 1'b0;
      bram_addr_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == STREAM) || (state_d == DRAIN);
      done_q  <= (state_q == DONE) && (state_d == DONE);
      if (set_ok) begin
        base_q    <= i_base_addr;
        len_q     <= i_length;
        issued_q  <= '0;
        emitted_q <= '0;
      end else if (start) begin
        issued_q  <= '0;
        emitted_q <= '0;
      end else begin
        issued_q  <= issued_d;
        emitted_q <= emitted_d;
      end
      bram_en_q <= issue;
      if (issue) bram_addr_q <= base_q + ADDR_WIDTH'(issued_q);
      pipe_q  <= {pipe_q[READ_LATENCY-1:0], issue};
      valid_q <= pop;
      if (pop) data_q <= head;
      if (push) begin
        buf_q[wr_ptr_q] <= i_bram_rdata;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_buf) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
    end
  end

`ifdef F2R_ROM_STREAMER_CHECKSUM_EN
  logic [15:0] csum_q;
  always_ff @(posedge i_clk) begin
    if (i_reset || set_ok || start) csum_q <= '0;
    else if (pop)                   csum_q <= csum_q + 16'(head);
  end
  assign o_checksum = csum_q;
`endif

  assert property (@(posedge i_clk) disable iff (i_reset)
    !(push && !pop_buf && (count_q == CW'(SKID_DEPTH))));

  assign o_rom_to_f2r_data  = data_q;
  assign o_rom_to_f2r_valid = valid_q;
  assign o_rom_read_done    = done_q;
  assign o_bram_en          = bram_en_q;
  assign o_bram_addr        = bram_addr_q;
  assign o_busy             = busy_q;

endmodule

// File: tb/tb_f2r_rom_streamer.sv
// Directed bench for f2r_rom_streamer: one instance at READ_LATENCY=1, one at READ_LATENCY=2.
module tb_f2r_rom_streamer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        r0, s0, e0, v0, dn0, be0, bz0;
  logic        r1, s1, e1, v1, dn1, be1, bz1;
  logic [11:0] b0, a0, b1, a1;
  logic [15:0] l0, l1;
  logic [7:0]  q0, q1, rd0, rd1, stg1;
`ifdef F2R_ROM_STREAMER_CHECKSUM_EN
  logic [15:0] cs0, cs1;
`endif

  logic [7:0] mem0 [4096];
  logic [7:0] mem1 [4096];

  always @(posedge clk) begin
    if (be0) rd0 <= mem0[a0];
    if (be1) stg1 <= mem1[a1];
    rd1 <= stg1;
  end

  f2r_rom_streamer #(.READ_LATENCY(1)) dut0 (
    .i_clk(clk), .i_reset(r0), .i_set_param(s0), .i_base_addr(b0), .i_length(l0),
    .i_en_rom(e0), .o_rom_to_f2r_data(q0), .o_rom_to_f2r_valid(v0),
    .o_rom_read_done(dn0), .o_bram_en(be0), .o_bram_addr(a0), .i_bram_rdata(rd0),
    .o_busy(bz0)
`ifdef F2R_ROM_STREAMER_CHECKSUM_EN
    , .o_checksum(cs0)
`endif
  );

  f2r_rom_streamer #(.READ_LATENCY(2)) dut1 (
    .i_clk(clk), .i_reset(r1), .i_set_param(s1), .i_base_addr(b1), .i_length(l1),
    .i_en_rom(e1), .o_rom_to_f2r_data(q1), .o_rom_to_f2r_valid(v1),
    .o_rom_read_done(dn1), .o_bram_en(be1), .o_bram_addr(a1), .i_bram_rdata(rd1),
    .o_busy(bz1)
`ifdef F2R_ROM_STREAMER_CHECKSUM_EN
    , .o_checksum(cs1)
`endif
  );

  typedef struct {
    logic       en;
    logic       v;
    logic [7:0] d;
    logic       dn;
    logic       be;
    logic       bz;
  } vec_t;

  vec_t tab [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_param(input int d, input logic [11:0] b, input logic [15:0] l);
    if (d == 0) begin s0 = 1'b1; b0 = b; l0 = l; end
    else        begin s1 = 1'b1; b1 = b; l1 = l; end
    tick();
    s0 = 1'b0;
    s1 = 1'b0;
  endtask

  // Collects a run whose element k is expected to equal k+1, stopping at read-done.
  task automatic run_expect(input int d, input int n, input int budget, input string name);
    int  idx;
    bit  fin;
    idx = 0;
    fin = 1'b0;
    for (int c = 0; c < budget && !fin; c++) begin
      tick();
      if ((d == 0) ? v0 : v1) begin
        chk($sformatf("%s data[%0d]", name, idx), 32'((d == 0) ? q0 : q1), 32'(idx + 1));
        idx++;
      end
      if ((d == 0) ? dn0 : dn1) fin = 1'b1;
    end
    chk({name, " count"}, 32'(idx), 32'(n));
    chk({name, " done"}, 32'(fin), 32'd1);
  endtask

  initial begin
    logic [11:0] wa [4];
    logic [7:0]  wd [4];
    {r0, s0, e0, r1, s1, e1} = 6'b100100;
    b0 = '0; b1 = '0; l0 = '0; l1 = '0;
    for (int i = 0; i < 4096; i++) begin
      mem0[i] = 8'(i + 1);
      mem1[i] = 8'h00;
    end
    mem1[12'hFFE] = 8'hFF;
    mem1[12'hFFF] = 8'hFE;
    mem1[12'h000] = 8'h05;
    mem1[12'h001] = 8'h06;

    tick();
    tick();
    r0 = 1'b0;
    r1 = 1'b0;
    chk("rst valid0", 32'(v0), 0);
    chk("rst done0",  32'(dn0), 0);
    chk("rst ben0",   32'(be0), 0);
    chk("rst busy0",  32'(bz0), 0);
    chk("rst data0",  32'(q0), 0);
    chk("rst valid1", 32'(v1), 0);
    chk("rst addr1",  32'(a1), 0);

    // Basic 4-element run at READ_LATENCY=1, row k is observed after edge T+k.
    tab[0] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
    tab[1] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1};
    tab[2] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1};
    tab[3] = '{1'b1, 1'b1, 8'd1, 1'b0, 1'b1, 1'b1};
    tab[4] = '{1'b1, 1'b1, 8'd2, 1'b0, 1'b1, 1'b1};
    tab[5] = '{1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b1};
    tab[6] = '{1'b1, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0};
    tab[7] = '{1'b1, 1'b0, 8'd4, 1'b1, 1'b0, 1'b0};
    tab[8] = '{1'b1, 1'b0, 8'd4, 1'b1, 1'b0, 1'b0};
    tab[9] = '{1'b0, 1'b0, 8'd4, 1'b0, 1'b0, 1'b0};
    set_param(0, 12'h000, 16'd4);
    for (int k = 0; k < 10; k++) begin
      e0 = tab[k].en;
      tick();
      chk($sformatf("t1 valid@%0d", k), 32'(v0),  32'(tab[k].v));
      chk($sformatf("t1 data@%0d", k),  32'(q0),  32'(tab[k].d));
      chk($sformatf("t1 done@%0d", k),  32'(dn0), 32'(tab[k].dn));
      chk($sformatf("t1 ben@%0d", k),   32'(be0), 32'(tab[k].be));
      chk($sformatf("t1 busy@%0d", k),  32'(bz0), 32'(tab[k].bz));
    end

    // Replay with a 3-cycle pause after the first valid.
    e0 = 1'b1;
    repeat (4) tick();
    chk("t2 first valid", 32'(v0), 1);
    chk("t2 first data",  32'(q0), 1);
    e0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t2 pause valid%0d", k), 32'(v0), 0);
      chk($sformatf("t2 pause hold%0d", k),  32'(q0), 1);
    end
    e0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t2 resume valid%0d", k), 32'(v0), 1);
      chk($sformatf("t2 resume data%0d", k),  32'(q0), 32'(k + 2));
    end
    tick();
    chk("t2 done",       32'(dn0), 1);
    chk("t2 post valid", 32'(v0), 0);
    e0 = 1'b0;
    tick();

    // Zero-length run.
    set_param(0, 12'h000, 16'd0);
    e0 = 1'b1;
    tick();
    chk("t3 valid@T", 32'(v0), 0);
    chk("t3 ben@T",   32'(be0), 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("t3 done@%0d", k),  32'(dn0), 1);
      chk($sformatf("t3 valid@%0d", k), 32'(v0), 0);
      chk($sformatf("t3 ben@%0d", k),   32'(be0), 0);
    end
    e0 = 1'b0;
    tick();
    chk("t3 done cleared", 32'(dn0), 0);

    // Address wrap at READ_LATENCY=2.
    wa[0] = 12'hFFE; wa[1] = 12'hFFF; wa[2] = 12'h000; wa[3] = 12'h001;
    wd[0] = 8'hFF;   wd[1] = 8'hFE;   wd[2] = 8'h05;   wd[3] = 8'h06;
    set_param(1, 12'hFFE, 16'd4);
    e1 = 1'b1;
    tick();
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk($sformatf("t4 ben@%0d", c), 32'(be1), (c <= 4) ? 32'd1 : 32'd0);
      if (c <= 4) chk($sformatf("t4 addr@%0d", c), 32'(a1), 32'(wa[c-1]));
      chk($sformatf("t4 valid@%0d", c), 32'(v1), (c >= 4 && c <= 7) ? 32'd1 : 32'd0);
      if (c >= 4 && c <= 7) chk($sformatf("t4 data@%0d", c), 32'(q1), 32'(wd[c-4]));
      chk($sformatf("t4 done@%0d", c), 32'(dn1), (c == 8) ? 32'd1 : 32'd0);
    end
`ifdef F2R_ROM_STREAMER_CHECKSUM_EN
    chk("t4 checksum", 32'(cs1), 32'h0008);
`endif
    e1 = 1'b0;
    tick();

    // Reset in the middle of a length-8 run, then a clean rerun.
    set_param(0, 12'h000, 16'd8);
    e0 = 1'b1;
    repeat (5) tick();
    chk("t5 second data", 32'(q0), 2);
    r0 = 1'b1;
    e0 = 1'b0;
    tick();
    r0 = 1'b0;
    chk("t5 rst valid", 32'(v0), 0);
    chk("t5 rst data",  32'(q0), 0);
    chk("t5 rst done",  32'(dn0), 0);
    chk("t5 rst ben",   32'(be0), 0);
    chk("t5 rst addr",  32'(a0), 0);
    chk("t5 rst busy",  32'(bz0), 0);
    set_param(0, 12'h000, 16'd8);
    e0 = 1'b1;
    run_expect(0, 8, 40, "t5 rerun");
    e0 = 1'b0;
    tick();

    // set_param during STREAM is ignored; the replay keeps the original length.
    set_param(0, 12'h000, 16'd4);
    e0 = 1'b1;
    tick();
    s0 = 1'b1; b0 = 12'h005; l0 = 16'd9;
    tick();
    s0 = 1'b0;
    run_expect(0, 4, 30, "t6 run");
`ifdef F2R_ROM_STREAMER_CHECKSUM_EN
    chk("t6 checksum", 32'(cs0), 32'd10);
`endif
    e0 = 1'b0;
    tick();
    e0 = 1'b1;
    run_expect(0, 4, 30, "t6 replay");
    e0 = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1);
  end
endmodule
